// File: rtl/fp_divider_if.sv
// Handshake and operand/result bundle shared by the ALU arithmetic units.
// The sequencer side uses master; the arithmetic unit uses slave.
interface fp_divider_if;
    logic        start;
    logic [31:0] input_a;
    logic [31:0] input_b;
    logic [31:0] output_z;
    logic        busy;
    logic        output_done;
    logic        overflow;
    logic        underflow;
    logic        div_by_zero;

    modport master (
        output start, input_a, input_b,
        input  output_z, busy, output_done, overflow, underflow, div_by_zero
    );
    modport slave (
        input  start, input_a, input_b,
        output output_z, busy, output_done, overflow, underflow, div_by_zero
    );
endinterface

// File: rtl/fp_divider.sv
// Multi-cycle IEEE-754 single divider, z = a / b: restoring radix-2 quotient, round-to-nearest-even.
// Define FP_DIV_FTZ_EN to flush denormal operands and results to signed zero.
module fp_divider #(
    parameter int          DIV_ITER = 27,
    parameter logic [31:0] QNAN     = 32'hFFC00000
) (
    input  logic        clk,
    input  logic        rst,
    fp_divider_if.slave bus
);
    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

    typedef enum logic [3:0] {
        S_IDLE, S_UNPACK, S_SPECIAL, S_NORM_A, S_NORM_B, S_DIV_INIT,
        S_DIV_ITER, S_NORM_Q, S_NORM_DN, S_ROUND, S_PACK, S_DONE
    } state_t;

    localparam logic [5:0]        ITER_LAST = 6'(DIV_ITER - 1);
    localparam logic signed [9:0] E_MIN     = -10'sd126;
    localparam logic signed [9:0] E_MAX     = 10'sd127;
`ifdef FP_DIV_FTZ_EN
    localparam state_t AFTER_SPECIAL = S_DIV_INIT;
    localparam state_t AFTER_NORM_Q  = S_ROUND;
`else
    localparam state_t AFTER_SPECIAL = S_NORM_A;
    localparam state_t AFTER_NORM_Q  = S_NORM_DN;
`endif

    state_t              state, state_d;
    fp32_t               a_r, b_r;
    logic                z_s;
    logic [23:0]         a_m, b_m, mant;
    logic signed [9:0]   a_e, b_e, z_e;
    logic [24:0]         rem;
    logic [DIV_ITER-1:0] q;
    logic [5:0]          cnt;
    logic                guard, rnd, sticky;
    logic [31:0]         z_r;
    logic                busy_r, done_r, ovf_r, unf_r, dbz_r;

    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, special;
    logic rem_ge, round_up, flush;
    logic [24:0] rem_nxt;

    assign a_inf  = (a_r.exp == 8'hFF) && (a_r.frac == '0);
    assign b_inf  = (b_r.exp == 8'hFF) && (b_r.frac == '0);
    assign a_nan  = (a_r.exp == 8'hFF) && (a_r.frac != '0);
    assign b_nan  = (b_r.exp == 8'hFF) && (b_r.frac != '0);
`ifdef FP_DIV_FTZ_EN
    assign a_zero = (a_r.exp == 8'h00);
    assign b_zero = (b_r.exp == 8'h00);
    assign flush  = (z_e < E_MIN);
`else
    assign a_zero = (a_r.exp == 8'h00) && (a_r.frac == '0);
    assign b_zero = (b_r.exp == 8'h00) && (b_r.frac == '0);
    assign flush  = 1'b0;
`endif
    assign special  = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
    // Both mantissas are normalised, so rem < 2*b_m and never outgrows 25 bits.
    assign rem_ge   = (rem >= {1'b0, b_m});
    assign rem_nxt  = rem_ge ? (rem - {1'b0, b_m}) : rem;
    assign round_up = guard & (rnd | sticky | mant[0]);

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:     if (bus.start && !busy_r) state_d = S_UNPACK;
            S_UNPACK:   state_d = S_SPECIAL;
            S_SPECIAL:  state_d = special ? S_DONE : AFTER_SPECIAL;
            S_NORM_A:   if (a_m[23]) state_d = S_NORM_B;
            S_NORM_B:   if (b_m[23]) state_d = S_DIV_INIT;
            S_DIV_INIT: state_d = S_DIV_ITER;
            S_DIV_ITER: if (cnt == ITER_LAST) state_d = S_NORM_Q;
            S_NORM_Q:   if (q[DIV_ITER-1]) state_d = AFTER_NORM_Q;
            S_NORM_DN:  if (!(z_e < E_MIN)) state_d = S_ROUND;
            S_ROUND:    state_d = S_PACK;
            S_PACK:     state_d = S_DONE;
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            a_r    <= '0;
            b_r    <= '0;
            z_s    <= 1'b0;
            a_m    <= '0;
            b_m    <= '0;
            mant   <= '0;
            a_e    <= '0;
            b_e    <= '0;
            z_e    <= '0;
            rem    <= '0;
            q      <= '0;
            cnt    <= '0;
            guard  <= 1'b0;
            rnd    <= 1'b0;
            sticky <= 1'b0;
            z_r    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            ovf_r  <= 1'b0;
            unf_r  <= 1'b0;
            dbz_r  <= 1'b0;
        end else begin
            state <= state_d;
            case (state)
                S_IDLE: if (bus.start && !busy_r) begin
                    a_r    <= bus.input_a;
                    b_r    <= bus.input_b;
                    busy_r <= 1'b1;
                    done_r <= 1'b0;
                    ovf_r  <= 1'b0;
                    unf_r  <= 1'b0;
                    dbz_r  <= 1'b0;
                end
                S_UNPACK: begin
                    z_s <= a_r.sign ^ b_r.sign;
                    a_m <= {a_r.exp != 8'h00, a_r.frac};
                    b_m <= {b_r.exp != 8'h00, b_r.frac};
                    a_e <= (a_r.exp == 8'h00) ? E_MIN : $signed({2'b00, a_r.exp}) - 10'sd127;
                    b_e <= (b_r.exp == 8'h00) ? E_MIN : $signed({2'b00, b_r.exp}) - 10'sd127;
                end
                S_SPECIAL: begin
                    if (a_nan | b_nan | (a_inf & b_inf) | (a_zero & b_zero)) begin
                        z_r <= QNAN;
                    end else if (a_inf | b_zero) begin
                        z_r   <= {z_s, 8'hFF, 23'h0};
                        dbz_r <= b_zero & ~a_inf;
                    end else if (a_zero | b_inf) begin
                        z_r <= {z_s, 31'h0};
                    end
                end
                S_NORM_A: if (!a_m[23]) begin
                    a_m <= a_m << 1;
                    a_e <= a_e - 10'sd1;
                end
                S_NORM_B: if (!b_m[23]) begin
                    b_m <= b_m << 1;
                    b_e <= b_e - 10'sd1;
                end
                S_DIV_INIT: begin
                    z_e <= a_e - b_e;
                    rem <= {1'b0, a_m};
                    q   <= '0;
                    cnt <= '0;
                end
                S_DIV_ITER: begin
                    q   <= {q[DIV_ITER-2:0], rem_ge};
                    rem <= rem_nxt << 1;
                    cnt <= cnt + 6'd1;
                end
                S_NORM_Q: begin
                    if (!q[DIV_ITER-1]) begin
                        q   <= q << 1;
                        z_e <= z_e - 10'sd1;
                    end else begin
                        mant   <= q[DIV_ITER-1 -: 24];
                        guard  <= q[DIV_ITER-25];
                        rnd    <= q[DIV_ITER-26];
                        sticky <= (|q[DIV_ITER-27:0]) | (|rem);
                    end
                end
                S_NORM_DN: if (z_e < E_MIN) begin
                    {mant, guard, rnd} <= {1'b0, mant, guard};
                    sticky             <= sticky | rnd;
                    z_e                <= z_e + 10'sd1;
                end
                S_ROUND: begin
                    if (flush) begin
                        mant <= '0;
                    end else if (round_up) begin
                        if (&mant) begin
                            mant <= 24'h800000;
                            z_e  <= z_e + 10'sd1;
                        end else begin
                            mant <= mant + 24'd1;
                        end
                    end
                end
                S_PACK: begin
                    if (z_e > E_MAX) begin
                        z_r   <= {z_s, 8'hFF, 23'h0};
                        ovf_r <= 1'b1;
                    end else if (mant == '0) begin
                        z_r   <= {z_s, 31'h0};
                        unf_r <= 1'b1;
                    end else if (!mant[23]) begin
                        z_r <= {z_s, 8'h00, mant[22:0]};
                    end else begin
                        z_r <= {z_s, 8'(z_e + 10'sd127), mant[22:0]};
                    end
                end
                S_DONE: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.output_z    = z_r;
    assign bus.busy        = busy_r;
    assign bus.output_done = done_r;
    assign bus.overflow    = ovf_r;
    assign bus.underflow   = unf_r;
    assign bus.div_by_zero = dbz_r;
endmodule
